// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent WIDTH-bit down-counters with per-channel
// 4-bit prescaler, reload register, auto-reload mode and interrupt.
// Register map per channel (addr[ADDR_W-1:2] = channel, addr[1:0] = word):
//   0 CTRL {CAPF[8], IE[7], EN[6], DONE[5], AUTO[4], PRE[3:0]}, 1 LOAD, 2 COUNT, 3 CAPT
// Optional feature: define TIMER_CAPTURE_EN to add cap_in[] edge capture into CAPT.
module multi_timer #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WIDTH-1:0]    wr_data,
`ifdef TIMER_CAPTURE_EN
  input  logic [CHANNELS-1:0] cap_in,
`endif
  output logic [WIDTH-1:0]    rd_data,
  output logic [CHANNELS-1:0] irq
);

  localparam logic [1:0] W_CTRL  = 2'd0;
  localparam logic [1:0] W_LOAD  = 2'd1;
  localparam logic [1:0] W_COUNT = 2'd2;
  localparam logic [1:0] W_CAPT  = 2'd3;

  logic [ADDR_W-1:0] ch_sel;
  logic [1:0]        word;

  logic [CHANNELS-1:0][3:0]       pre, pre_n, psc, psc_n;
  logic [CHANNELS-1:0]            auto_rl, auto_n, done, done_n, en, en_n, ie, ie_n;
  logic [CHANNELS-1:0][WIDTH-1:0] count, count_n, load, load_n;
  logic [CHANNELS-1:0]            wr_ctrl, wr_load, wr_count, tick, hw_done;
  logic [WIDTH-1:0]               rd_mux;

`ifdef TIMER_CAPTURE_EN
  logic [CHANNELS-1:0]            cap_s1, cap_s2, cap_s3, cap_edge;
  logic [CHANNELS-1:0]            capf, capf_n;
  logic [CHANNELS-1:0][WIDTH-1:0] capt, capt_n;
  logic                           capf_clr_bit;
`endif

  assign ch_sel = addr >> 2;
  assign word   = addr[1:0];

  // Interrupt is a pure AND of flops: no path from any input.
  assign irq = done & ie;

  function automatic logic [WIDTH-1:0] ctrl_word(input logic [3:0] p, input logic a,
                                                 input logic dn, input logic e,
                                                 input logic ie_b, input logic cf);
    return WIDTH'({cf, ie_b, e, dn, a, p});
  endfunction

  // Per-channel next state: write decode, prescaler, count/reload and DONE/EN arbitration.
  always_comb begin
    wr_ctrl  = '0;
    wr_load  = '0;
    wr_count = '0;
    tick     = '0;
    hw_done  = '0;
    pre_n    = pre;
    auto_n   = auto_rl;
    done_n   = done;
    en_n     = en;
    ie_n     = ie;
    psc_n    = psc;
    count_n  = count;
    load_n   = load;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_ctrl[i]  = wr_en && (ch_sel == ADDR_W'(i)) && (word == W_CTRL);
      wr_load[i]  = wr_en && (ch_sel == ADDR_W'(i)) && (word == W_LOAD);
      wr_count[i] = wr_en && (ch_sel == ADDR_W'(i)) && (word == W_COUNT);
      tick[i]     = en[i] && (psc[i] == pre[i]);
      // A COUNT write swallows the tick, so it can neither set DONE nor drop EN.
      hw_done[i]  = tick[i] && (count[i] == '0) && !wr_count[i];

      // Prescaler sits at 0 while disabled, which also makes an EN 0->1 write start from 0.
      if (wr_count[i] || !en[i] || tick[i])
        psc_n[i] = 4'd0;
      else
        psc_n[i] = psc[i] + 4'd1;

      if (wr_count[i])
        count_n[i] = wr_data;
      else if (tick[i]) begin
        if (count[i] != '0)
          count_n[i] = count[i] - WIDTH'(1);
        else if (auto_rl[i])
          count_n[i] = load[i];
      end

      // Software EN write beats the hardware one-shot clear.
      if (wr_ctrl[i]) begin
        pre_n[i]  = wr_data[3:0];
        auto_n[i] = wr_data[4];
        en_n[i]   = wr_data[6];
        ie_n[i]   = wr_data[7];
      end else if (hw_done[i] && !auto_rl[i]) begin
        en_n[i] = 1'b0;
      end

      // Hardware set beats the write-1-to-clear.
      done_n[i] = hw_done[i] | (done[i] & ~(wr_ctrl[i] & wr_data[5]));

      if (wr_load[i])
        load_n[i] = wr_data;
    end
  end

`ifdef TIMER_CAPTURE_EN
  assign cap_edge     = cap_s2 & ~cap_s3;
  assign capf_clr_bit = |(9'(wr_data) & 9'h100);

  // Capture latches the pre-edge COUNT; a capture beats a same-cycle CAPF clear.
  always_comb begin
    capt_n = capt;
    capf_n = capf;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cap_edge[i])
        capt_n[i] = count[i];
      capf_n[i] = cap_edge[i] | (capf[i] & ~(wr_ctrl[i] & capf_clr_bit));
    end
  end
`endif

  // Read mux: unmapped channels and absent words read as 0.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == ADDR_W'(i)) begin
        case (word)
`ifdef TIMER_CAPTURE_EN
          W_CTRL:  rd_mux = ctrl_word(pre[i], auto_rl[i], done[i], en[i], ie[i], capf[i]);
          W_CAPT:  rd_mux = capt[i];
`else
          W_CTRL:  rd_mux = ctrl_word(pre[i], auto_rl[i], done[i], en[i], ie[i], 1'b0);
          W_CAPT:  rd_mux = '0;
`endif
          W_LOAD:  rd_mux = load[i];
          default: rd_mux = count[i];
        endcase
      end
    end
  end

  // Register stage: channel state and the one-cycle read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre     <= '0;
      auto_rl <= '0;
      done    <= '0;
      en      <= '0;
      ie      <= '0;
      psc     <= '0;
      count   <= '0;
      load    <= '0;
      rd_data <= '0;
`ifdef TIMER_CAPTURE_EN
      cap_s1  <= '0;
      cap_s2  <= '0;
      cap_s3  <= '0;
      capf    <= '0;
      capt    <= '0;
`endif
    end else begin
      pre     <= pre_n;
      auto_rl <= auto_n;
      done    <= done_n;
      en      <= en_n;
      ie      <= ie_n;
      psc     <= psc_n;
      count   <= count_n;
      load    <= load_n;
      rd_data <= rd_mux;
`ifdef TIMER_CAPTURE_EN
      cap_s1  <= cap_in;
      cap_s2  <= cap_s1;
      cap_s3  <= cap_s2;
      capf    <= capf_n;
      capt    <= capt_n;
`endif
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Testbench for multi_timer (default build, TIMER_CAPTURE_EN undefined).
// Directed scenarios with fixed expectations plus randomized traffic,
// every cycle compared against a behavioural register-map model.
module tb_multi_timer;

  localparam int W  = 16;
  localparam int CH = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] addr;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd_data;
  logic [CH-1:0] irq;

  always #5 clk = ~clk;

  multi_timer #(.WIDTH(W), .CHANNELS(CH), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq     (irq)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state, one entry per channel.
  int m_pre[CH], m_auto[CH], m_done[CH], m_en[CH], m_ie[CH], m_psc[CH], m_cnt[CH], m_load[CH];
  logic [W-1:0]  exp_rd;
  logic [CH-1:0] exp_irq;

  int oneshot_exp[7] = '{3, 3, 2, 2, 1, 1, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int word_of(input int ch, input int w);
    if (ch >= CH) return 0;
    case (w)
      0:       return m_pre[ch] | (m_auto[ch] << 4) | (m_done[ch] << 5) | (m_en[ch] << 6) | (m_ie[ch] << 7);
      1:       return m_load[ch];
      2:       return m_cnt[ch];
      default: return 0;
    endcase
  endfunction

  // One clock edge of the register-map rules, applied to pre-edge state.
  task automatic model_step(input bit r, input bit we, input int a, input int d);
    int ch;
    int w;
    ch = a >> 2;
    w  = a & 3;
    if (r) begin
      for (int c = 0; c < CH; c++) begin
        m_pre[c] = 0; m_auto[c] = 0; m_done[c] = 0; m_en[c] = 0;
        m_ie[c] = 0; m_psc[c] = 0; m_cnt[c] = 0; m_load[c] = 0;
      end
      exp_rd  = '0;
      exp_irq = '0;
      return;
    end
    exp_rd = W'(word_of(ch, w));
    for (int c = 0; c < CH; c++) begin
      bit wr;
      bit tk;
      bit hw;
      int was_en;
      wr     = we && (ch == c);
      tk     = (m_en[c] != 0) && (m_psc[c] == m_pre[c]);
      hw     = 1'b0;
      was_en = m_en[c];
      if (m_en[c] == 0 || tk) m_psc[c] = 0;
      else m_psc[c] = (m_psc[c] + 1) % 16;
      if (wr && w == 2) begin
        m_cnt[c] = d;
        m_psc[c] = 0;
      end else if (tk) begin
        if (m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
        else begin
          hw = 1'b1;
          m_done[c] = 1;
          if (m_auto[c] != 0) m_cnt[c] = m_load[c];
          else m_en[c] = 0;
        end
      end
      if (wr && w == 0) begin
        m_pre[c]  = d & 15;
        m_auto[c] = (d >> 4) & 1;
        if (((d >> 5) & 1) != 0 && !hw) m_done[c] = 0;
        m_en[c]   = (d >> 6) & 1;
        m_ie[c]   = (d >> 7) & 1;
        if (was_en == 0 && m_en[c] != 0) m_psc[c] = 0;
      end
      if (wr && w == 1) m_load[c] = d;
      exp_irq[c] = (m_done[c] != 0) && (m_ie[c] != 0);
    end
  endtask

  task automatic cycle(input bit r, input bit we, input int a, input int d);
    rst     = r;
    wr_en   = we;
    addr    = AW'(a);
    wr_data = W'(d);
    @(posedge clk);
    model_step(r, we, a, d & 16'hFFFF);
    #1;
    chk("rd_data", 32'(rd_data), 32'(exp_rd));
    chk("irq", 32'(irq), 32'(exp_irq));
  endtask

  initial begin
    int a;
    int d;
    bit r;
    bit we;
    rst = 1'b1; wr_en = 1'b0; addr = '0; wr_data = '0;

    // Reset state
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("reset_rd", 32'(rd_data), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    cycle(0, 0, 2, 0);
    chk("reset_cnt", 32'(rd_data), 32'h0);

    // One-shot: ch0 COUNT=3, CTRL=0x41
    cycle(0, 1, 2, 3);
    cycle(0, 1, 0, 'h41);
    for (int k = 0; k < 7; k++) begin
      cycle(0, 0, 2, 0);
      chk("oneshot_cnt", 32'(rd_data), 32'(oneshot_exp[k]));
    end
    cycle(0, 0, 0, 0);
    chk("oneshot_ctrl_pre", 32'(rd_data), 32'h41);
    cycle(0, 0, 0, 0);
    chk("oneshot_ctrl_done", 32'(rd_data), 32'h21);
    chk("oneshot_irq", 32'(irq[0]), 32'h0);

    // Auto-reload with interrupt on ch1
    cycle(0, 1, 5, 2);
    cycle(0, 1, 6, 2);
    cycle(0, 1, 4, 'hD0);
    cycle(0, 0, 6, 0);
    chk("auto_irq_t1", 32'(irq[1]), 32'h0);
    cycle(0, 0, 6, 0);
    chk("auto_irq_t2", 32'(irq[1]), 32'h0);
    cycle(0, 0, 6, 0);
    chk("auto_irq_t3", 32'(irq[1]), 32'h1);
    chk("auto_cnt_t2", 32'(rd_data), 32'h0);
    cycle(0, 1, 4, 'hF0);
    chk("auto_clr_irq", 32'(irq), 32'h0);
    cycle(0, 0, 4, 0);
    chk("auto_clr_ctrl", 32'(rd_data), 32'hD0);
    cycle(0, 0, 6, 0);
    chk("auto_period_irq", 32'(irq), 32'h2);

    // Collision: DONE clear on the DONE-setting tick, COUNT write on a tick
    cycle(0, 0, 6, 0);
    cycle(0, 0, 6, 0);
    cycle(0, 1, 4, 'hF0);
    cycle(0, 0, 4, 0);
    chk("coll_done_ctrl", 32'(rd_data), 32'hF0);
    chk("coll_done_irq", 32'(irq), 32'h2);
    cycle(0, 1, 6, 5);
    cycle(0, 0, 6, 0);
    chk("coll_cnt_write", 32'(rd_data), 32'h5);
    cycle(0, 0, 6, 0);
    chk("coll_cnt_next", 32'(rd_data), 32'h4);

    // Unmapped channel 3: writes ignored, reads 0
    cycle(0, 1, 12, 'hFF);
    cycle(0, 1, 14, 9);
    cycle(0, 0, 14, 0);
    chk("unmapped_cnt", 32'(rd_data), 32'h0);
    cycle(0, 0, 12, 0);
    chk("unmapped_ctrl", 32'(rd_data), 32'h0);
    cycle(0, 0, 0, 0);
    chk("ch0_untouched", 32'(rd_data), 32'h21);

    // Reset mid-run: ch0 COUNT=7 running at PRE=15
    cycle(0, 1, 2, 7);
    cycle(0, 1, 0, 'h4F);
    for (int k = 0; k < 5; k++) cycle(0, 0, 2, 0);
    cycle(1, 0, 2, 0);
    chk("midrst_rd", 32'(rd_data), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    cycle(0, 0, 0, 0);
    chk("midrst_ctrl0", 32'(rd_data), 32'h0);
    cycle(0, 0, 2, 0);
    chk("midrst_cnt0", 32'(rd_data), 32'h0);
    for (int k = 0; k < 150; k++) cycle(0, 0, 0, 0);
    chk("midrst_no_done", 32'(rd_data), 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 2) == 0);
      a  = $urandom_range(0, 15);
      d  = $urandom & 'hFFFF;
      if ((a & 3) == 0) d = (d & 'hFFF0) | $urandom_range(0, 3);
      else if ((a & 3) != 3) d = $urandom_range(0, 6);
      cycle(r, we, a, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
